scoreboard: RTL and testbench
=============================

// Module: scoreboard
// PURPOSE
//  In-order circular buffer of ariane_pkg::scoreboard_entry between ID and EX/commit.
//  Accepts decoded instructions from ID and hands them to issue in program order.
//  Takes out-of-order writebacks from the FUs and retires entries in order to commit.
//  Also drives per-register clobber and operand-forwarding data for hazard checks.
// PARAMETERS
//  NR_ENTRIES  8  buffer depth; power of two, >=2; TRANS_ID_BITS = $clog2(NR_ENTRIES)
// PORTS
//  clk_i               in   1    clock, rising edge
//  rst_i               in   1    synchronous reset, active-high
//  flush_i             in   1    discard all in-flight entries
//  full_o              out  1    count == NR_ENTRIES
//  decoded_instr_i     in   SE   scoreboard_entry from ID
//  decoded_valid_i     in   1    ID offers decoded_instr_i
//  decoded_ack_o       out  1    entry accepted this cycle
//  issue_instr_o       out  SE   oldest not-yet-issued entry
//  issue_trans_id_o    out  TID  slot index of issue_instr_o
//  issue_valid_o       out  1    issue_instr_o is meaningful
//  issue_ack_i         in   1    issue consumed issue_instr_o
//  wb_valid_i          in   1    FU writeback strobe
//  wb_trans_id_i       in   TID  slot being written back
//  wb_result_i         in   64   result value
//  wb_ex_i             in   EX   exception; wb_ex_i.valid flags a fault
//  commit_instr_o      out  SE   entry at head
//  commit_valid_o      out  1    head is occupied and its result has been written
//  commit_ack_i        in   1    commit retired the head
//  rs1_i, rs2_i        in   5    source registers queried by issue
//  rs1_o, rs2_o        out  64   forwarded operand
//  rs1_valid_o, rs2_valid_o  out 1  forwarded operand is usable
//  rd_clobber_o        out  32x4 fu_t per architectural register; NONE means no pending writer
// BEHAVIOUR
//  State: mem[NR_ENTRIES] of SE; per-slot busy bit; pointers head, issue_ptr and tail (TID bits each);
//   count (TID+1 bits). All pointers wrap modulo NR_ENTRIES.
//  Reset (rst_i=1 at clk edge): pointers=0, count=0, busy=0, entry valid bits=0.
//   Resulting outputs: full_o=0, issue_valid_o=0, commit_valid_o=0, rd_clobber_o all NONE, rs*_valid_o=0.
//   Reset mid-operation drops all entries; no output pulses on the cycle after.
//  Push: decoded_ack_o = decoded_valid_i & ~full_o & ~flush_i, combinational.
//   On ack: mem[tail] <= entry with .valid=0; busy[tail]<=1; tail++.
//   full_o depends on the registered count only, so a commit in the same cycle does not free a slot for the push.
//  Issue: issue_valid_o = (issue_ptr != tail) | (count==NR_ENTRIES & issue_ptr==tail & busy[issue_ptr] & not-yet-issued).
//   Track issued state with an explicit per-slot issued bit.
//   issue_ack_i while issue_valid_o=1 advances issue_ptr. An ack while issue_valid_o=0 is ignored.
//   An entry pushed in cycle N is issuable from cycle N+1 (1-cycle latency).
//  Writeback: when wb_valid_i and busy[wb_trans_id_i]: result<=wb_result_i; ex<=wb_ex_i; valid<=1.
//   A writeback to a non-busy slot is ignored.
//   Out-of-order writebacks are allowed; only one writeback per cycle.
//  Commit: commit_valid_o = busy[head] & mem[head].valid.
//   commit_ack_i with commit_valid_o: busy[head]<=0, head++.
//   An entry written back in cycle N is committable from cycle N+1.
//   Exceptions are passed through unchanged; commit decides what to do with them.
//  count: +1 on push, -1 on commit; push and commit in the same cycle leave count unchanged.
//  Flush: takes priority over push, writeback, issue and commit in the same cycle.
//   Next cycle: all busy=0, head=issue_ptr=tail=0, count=0.
//  rd_clobber_o[r]: fu of the youngest busy entry with rd==r. Combinational from registered state.
//   rd_clobber_o[0] is always NONE.
//  Forwarding rsX: scan busy entries from youngest to oldest for rd==rsX.
//   If the youngest match has .valid=1: rsX_o=result and rsX_valid_o=1.
//   Otherwise rsX_valid_o=0 and rsX_o=0.
//   rsX==0 always gives rsX_valid_o=0. A writeback in the same cycle is not forwarded; it appears next cycle.
//  No combinational path from wb_* or commit_ack_i to any output; decoded_ack_o depends on decoded_valid_i and flush_i.
// TESTING
//  T1 fill: push 9 entries, no commit -> acks 1..8, full_o=1 after 8th, 9th ack=0, tail wraps to 0.
//  T2 OoO wb: 3 entries; wb id2=0x33, id0=0x11, id1=0x22 ->
//     commit_valid_o rises only after id0 written; retires 0x11,0x22,0x33 in order.
//  T3 forward: entry0 rd=x5 wb=0xA, entry1 rd=x5 pending; rs1_i=5 -> rs1_valid_o=0.
//     After wb id1=0xB, next cycle: rs1_o=0xB, rs1_valid_o=1. rs1_i=0 -> rs1_valid_o=0.
//  T4 full+commit: full with head written; same cycle push and commit_ack -> push ack=0, count=7; next cycle push accepted.
//  T5 flush: 5 in flight with flush_i plus push and wb in same cycle -> next cycle count=0,
//     issue/commit_valid_o=0, rd_clobber_o all NONE.
//  T6 reset: rst_i pulsed with 4 entries in flight -> all outputs at reset values the next cycle; a fresh push lands at slot 0.

Source files
------------

// File: rtl/scoreboard_if.sv
// Scoreboard entry types and the ID/issue/writeback/commit bundle
// shared by the scoreboard and its neighbours.
package ariane_pkg;
  typedef enum logic [3:0] {
    NONE, LOAD, STORE, ALU, CTRL_FLOW, MULT, CSR
  } fu_t;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic [63:0] pc;
    fu_t         fu;
    logic [7:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] result;
    logic        valid;
    exception_t  ex;
  } scoreboard_entry_t;
endpackage

interface scoreboard_if #(
  parameter int unsigned TID_W = 3
);
  import ariane_pkg::*;

  logic              flush_i;
  logic              full_o;
  scoreboard_entry_t decoded_instr_i;
  logic              decoded_valid_i;
  logic              decoded_ack_o;
  scoreboard_entry_t issue_instr_o;
  logic [TID_W-1:0]  issue_trans_id_o;
  logic              issue_valid_o;
  logic              issue_ack_i;
  logic              wb_valid_i;
  logic [TID_W-1:0]  wb_trans_id_i;
  logic [63:0]       wb_result_i;
  exception_t        wb_ex_i;
  scoreboard_entry_t commit_instr_o;
  logic              commit_valid_o;
  logic              commit_ack_i;
  logic [4:0]        rs1_i;
  logic [4:0]        rs2_i;
  logic [63:0]       rs1_o;
  logic [63:0]       rs2_o;
  logic              rs1_valid_o;
  logic              rs2_valid_o;
  fu_t [31:0]        rd_clobber_o;

  modport slave (
    input  flush_i, decoded_instr_i,
    input  decoded_valid_i, issue_ack_i,
    input  wb_valid_i, wb_trans_id_i,
    input  wb_result_i, wb_ex_i,
    input  commit_ack_i, rs1_i, rs2_i,
    output full_o, decoded_ack_o,
    output issue_instr_o, issue_trans_id_o,
    output issue_valid_o, commit_instr_o,
    output commit_valid_o, rs1_o, rs2_o,
    output rs1_valid_o, rs2_valid_o,
    output rd_clobber_o
  );

  modport master (
    output flush_i, decoded_instr_i,
    output decoded_valid_i, issue_ack_i,
    output wb_valid_i, wb_trans_id_i,
    output wb_result_i, wb_ex_i,
    output commit_ack_i, rs1_i, rs2_i,
    input  full_o, decoded_ack_o,
    input  issue_instr_o, issue_trans_id_o,
    input  issue_valid_o, commit_instr_o,
    input  commit_valid_o, rs1_o, rs2_o,
    input  rs1_valid_o, rs2_valid_o,
    input  rd_clobber_o
  );
endinterface

// File: rtl/scoreboard.sv
// In-order instruction scoreboard: circular buffer between ID and
// issue/commit with out-of-order writeback, clobber and forwarding.
module scoreboard
  import ariane_pkg::*;
#(
  parameter int unsigned NR_ENTRIES = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  scoreboard_if.slave sb
);
  localparam int unsigned TW = $clog2(NR_ENTRIES);
  typedef logic [TW-1:0] ptr_t;

  scoreboard_entry_t     mem_q [NR_ENTRIES];
  scoreboard_entry_t     mem_d [NR_ENTRIES];
  logic [NR_ENTRIES-1:0] busy_q, busy_d;
  logic [NR_ENTRIES-1:0] issued_q, issued_d;
  ptr_t                  head_q, head_d;
  ptr_t                  iss_q, iss_d;
  ptr_t                  tail_q, tail_d;
  logic [TW:0]           cnt_q, cnt_d;

  logic full, push, pop, iss_fire, wb_hit;
  logic iss_valid, cmt_valid;
  ptr_t ord [NR_ENTRIES];

  assign full = (cnt_q == (TW+1)'(NR_ENTRIES));
  assign push = sb.decoded_valid_i & ~full
              & ~sb.flush_i;

  assign iss_valid = (iss_q != tail_q)
    | (full & (iss_q == tail_q)
       & busy_q[iss_q] & ~issued_q[iss_q]);
  assign cmt_valid = busy_q[head_q]
                   & mem_q[head_q].valid;

  assign iss_fire = sb.issue_ack_i & iss_valid
                  & ~sb.flush_i;
  assign pop = sb.commit_ack_i & cmt_valid
             & ~sb.flush_i;
  assign wb_hit = sb.wb_valid_i
                & busy_q[sb.wb_trans_id_i]
                & ~sb.flush_i;

  assign sb.full_o           = full;
  assign sb.decoded_ack_o    = push;
  assign sb.issue_instr_o    = mem_q[iss_q];
  assign sb.issue_trans_id_o = iss_q;
  assign sb.issue_valid_o    = iss_valid;
  assign sb.commit_instr_o   = mem_q[head_q];
  assign sb.commit_valid_o   = cmt_valid;

  always_comb begin
    mem_d    = mem_q;
    busy_d   = busy_q;
    issued_d = issued_q;
    head_d   = head_q;
    iss_d    = iss_q;
    tail_d   = tail_q;
    cnt_d    = cnt_q;
    if (sb.flush_i) begin
      busy_d   = '0;
      issued_d = '0;
      head_d   = '0;
      iss_d    = '0;
      tail_d   = '0;
      cnt_d    = '0;
      for (int i = 0; i < NR_ENTRIES; i++)
        mem_d[i].valid = 1'b0;
    end else begin
      if (push) begin
        mem_d[tail_q]       = sb.decoded_instr_i;
        mem_d[tail_q].valid = 1'b0;
        busy_d[tail_q]      = 1'b1;
        issued_d[tail_q]    = 1'b0;
        tail_d              = tail_q + ptr_t'(1);
      end
      if (wb_hit) begin
        mem_d[sb.wb_trans_id_i].result = sb.wb_result_i;
        mem_d[sb.wb_trans_id_i].ex     = sb.wb_ex_i;
        mem_d[sb.wb_trans_id_i].valid  = 1'b1;
      end
      if (iss_fire) begin
        issued_d[iss_q] = 1'b1;
        iss_d           = iss_q + ptr_t'(1);
      end
      if (pop) begin
        busy_d[head_q] = 1'b0;
        head_d         = head_q + ptr_t'(1);
      end
      if (push & ~pop)
        cnt_d = cnt_q + 1'b1;
      else if (pop & ~push)
        cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q   <= '0;
      issued_q <= '0;
      head_q   <= '0;
      iss_q    <= '0;
      tail_q   <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < NR_ENTRIES; i++)
        mem_q[i].valid <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      busy_q   <= busy_d;
      issued_q <= issued_d;
      head_q   <= head_d;
      iss_q    <= iss_d;
      tail_q   <= tail_d;
      cnt_q    <= cnt_d;
    end
  end

  // ord[k] walks live slots oldest (k=0) to youngest
  for (genvar k = 0; k < NR_ENTRIES; k++) begin : g_ord
    assign ord[k] = head_q + ptr_t'(k);
  end

  always_comb begin
    for (int r = 0; r < 32; r++)
      sb.rd_clobber_o[r] = NONE;
    for (int k = 0; k < NR_ENTRIES; k++)
      if (busy_q[ord[k]])
        sb.rd_clobber_o[mem_q[ord[k]].rd] =
          mem_q[ord[k]].fu;
    sb.rd_clobber_o[0] = NONE;
  end

  function automatic logic [64:0] fwd(
    input logic [4:0] rs
  );
    logic [64:0] r;
    r = '0;
    for (int k = 0; k < NR_ENTRIES; k++)
      if (busy_q[ord[k]] && mem_q[ord[k]].rd == rs)
        r = mem_q[ord[k]].valid
          ? {1'b1, mem_q[ord[k]].result} : '0;
    if (rs == 5'd0) r = '0;
    return r;
  endfunction

  always_comb begin
    {sb.rs1_valid_o, sb.rs1_o} = fwd(sb.rs1_i);
    {sb.rs2_valid_o, sb.rs2_o} = fwd(sb.rs2_i);
  end
endmodule

// File: tb/tb_scoreboard.sv
// Directed bench for the scoreboard: fill, OoO writeback,
// forwarding, full+commit, flush and reset.
module tb_scoreboard;
  import ariane_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_n = 0;
  int   chk_n  = 0;

  always #5 clk = ~clk;

  scoreboard_if #(.TID_W(3)) sb();

  scoreboard #(.NR_ENTRIES(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .sb    (sb)
  );

  function automatic scoreboard_entry_t mk(
    input logic [4:0]  rd,
    input fu_t         fu,
    input logic [63:0] pc
  );
    scoreboard_entry_t e;
    e    = '0;
    e.pc = pc;
    e.fu = fu;
    e.rd = rd;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic push_e(input scoreboard_entry_t e);
    sb.decoded_instr_i = e;
    sb.decoded_valid_i = 1'b1;
    step();
    sb.decoded_valid_i = 1'b0;
  endtask

  task automatic wb(
    input logic [2:0]  id,
    input logic [63:0] v
  );
    sb.wb_valid_i    = 1'b1;
    sb.wb_trans_id_i = id;
    sb.wb_result_i   = v;
  endtask

  function automatic bit clob_clear();
    bit ok;
    ok = 1'b1;
    for (int r = 0; r < 32; r++)
      if (sb.rd_clobber_o[r] !== NONE) ok = 1'b0;
    return ok;
  endfunction

  task automatic test_reset();
    do_reset();
    step();
    chk_n++;
    if ({sb.full_o, sb.issue_valid_o,
         sb.commit_valid_o} !== 3'b000)
      $display("FAIL rst_flags got=%b exp=000",
        {sb.full_o, sb.issue_valid_o,
         sb.commit_valid_o});
    else pass_n++;
    chk_n++;
    if (clob_clear() !== 1'b1)
      $display("FAIL rst_clobber got=busy exp=NONE");
    else pass_n++;
    sb.rs1_i = 5'd3;
    #1;
    chk_n++;
    if (sb.rs1_valid_o !== 1'b0)
      $display("FAIL rst_rs1v got=%b exp=0",
        sb.rs1_valid_o);
    else pass_n++;
    sb.issue_ack_i = 1'b1;
    step();
    sb.issue_ack_i = 1'b0;
    push_e(mk(5'd3, ALU, 64'h40));
    chk_n++;
    if ({sb.issue_valid_o, sb.issue_trans_id_o}
        !== 4'b1000)
      $display("FAIL rst_ign_ack got=%b exp=1000",
        {sb.issue_valid_o, sb.issue_trans_id_o});
    else pass_n++;
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      sb.decoded_instr_i =
        mk(5'(i + 1), ALU, 64'(i));
      sb.decoded_valid_i = 1'b1;
      #1;
      chk_n++;
      if (sb.decoded_ack_o !== (i < 8))
        $display("FAIL fill_ack%0d got=%b exp=%b",
          i, sb.decoded_ack_o, (i < 8));
      else pass_n++;
      step();
    end
    sb.decoded_valid_i = 1'b0;
    chk_n++;
    if (sb.full_o !== 1'b1)
      $display("FAIL fill_full got=%b exp=1",
        sb.full_o);
    else pass_n++;
    sb.issue_ack_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk_n++;
      if ({sb.issue_valid_o, sb.issue_trans_id_o}
          !== {1'b1, 3'(i)})
        $display("FAIL fill_iss%0d got=%b exp=%b",
          i, {sb.issue_valid_o, sb.issue_trans_id_o},
          {1'b1, 3'(i)});
      else pass_n++;
      step();
    end
    sb.issue_ack_i = 1'b0;
    #1;
    chk_n++;
    if (sb.issue_valid_o !== 1'b0)
      $display("FAIL fill_iss_end got=%b exp=0",
        sb.issue_valid_o);
    else pass_n++;
  endtask

  task automatic test_ooo_wb();
    logic [63:0] exp_r [3];
    exp_r[0] = 64'h11;
    exp_r[1] = 64'h22;
    exp_r[2] = 64'h33;
    do_reset();
    for (int i = 0; i < 3; i++)
      push_e(mk(5'(i + 1), ALU, 64'(i)));
    wb(3'd2, 64'h33);
    step();
    sb.wb_valid_i = 1'b0;
    chk_n++;
    if (sb.commit_valid_o !== 1'b0)
      $display("FAIL ooo_cv_id2 got=%b exp=0",
        sb.commit_valid_o);
    else pass_n++;
    wb(3'd0, 64'h11);
    #1;
    chk_n++;
    if (sb.commit_valid_o !== 1'b0)
      $display("FAIL ooo_cv_comb got=%b exp=0",
        sb.commit_valid_o);
    else pass_n++;
    step();
    sb.wb_valid_i = 1'b0;
    chk_n++;
    if (sb.commit_valid_o !== 1'b1)
      $display("FAIL ooo_cv_id0 got=%b exp=1",
        sb.commit_valid_o);
    else pass_n++;
    wb(3'd1, 64'h22);
    sb.wb_ex_i.valid = 1'b1;
    step();
    sb.wb_valid_i = 1'b0;
    sb.wb_ex_i    = '0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk_n++;
      if ({sb.commit_valid_o,
           sb.commit_instr_o.result}
          !== {1'b1, exp_r[k]})
        $display("FAIL ooo_ret%0d got=%0h exp=%0h",
          k, sb.commit_instr_o.result, exp_r[k]);
      else pass_n++;
      chk_n++;
      if (sb.commit_instr_o.ex.valid !== (k == 1))
        $display("FAIL ooo_ex%0d got=%b exp=%b",
          k, sb.commit_instr_o.ex.valid, (k == 1));
      else pass_n++;
      sb.commit_ack_i = 1'b1;
      step();
      sb.commit_ack_i = 1'b0;
    end
    chk_n++;
    if (sb.commit_valid_o !== 1'b0)
      $display("FAIL ooo_empty got=%b exp=0",
        sb.commit_valid_o);
    else pass_n++;
  endtask

  task automatic test_forward();
    do_reset();
    push_e(mk(5'd5, ALU, 64'h0));
    push_e(mk(5'd5, LOAD, 64'h4));
    wb(3'd0, 64'hA);
    step();
    sb.wb_valid_i = 1'b0;
    sb.rs1_i = 5'd5;
    sb.rs2_i = 5'd5;
    #1;
    chk_n++;
    if (sb.rs1_valid_o !== 1'b0)
      $display("FAIL fwd_pend got=%b exp=0",
        sb.rs1_valid_o);
    else pass_n++;
    chk_n++;
    if (sb.rd_clobber_o[5] !== LOAD)
      $display("FAIL fwd_clob got=%0d exp=%0d",
        sb.rd_clobber_o[5], LOAD);
    else pass_n++;
    wb(3'd1, 64'hB);
    #1;
    chk_n++;
    if (sb.rs1_valid_o !== 1'b0)
      $display("FAIL fwd_same got=%b exp=0",
        sb.rs1_valid_o);
    else pass_n++;
    step();
    sb.wb_valid_i = 1'b0;
    chk_n++;
    if ({sb.rs1_valid_o, sb.rs1_o}
        !== {1'b1, 64'hB})
      $display("FAIL fwd_rs1 got=%0h exp=1000b",
        {sb.rs1_valid_o, sb.rs1_o});
    else pass_n++;
    chk_n++;
    if ({sb.rs2_valid_o, sb.rs2_o}
        !== {1'b1, 64'hB})
      $display("FAIL fwd_rs2 got=%0h exp=1000b",
        {sb.rs2_valid_o, sb.rs2_o});
    else pass_n++;
    sb.rs1_i = 5'd0;
    sb.rs2_i = 5'd6;
    #1;
    chk_n++;
    if ({sb.rs1_valid_o, sb.rs2_valid_o}
        !== 2'b00)
      $display("FAIL fwd_x0 got=%b exp=00",
        {sb.rs1_valid_o, sb.rs2_valid_o});
    else pass_n++;
  endtask

  task automatic test_full_commit();
    do_reset();
    for (int i = 0; i < 8; i++)
      push_e(mk(5'(i + 1), ALU, 64'(256 + i)));
    wb(3'd0, 64'h5);
    step();
    sb.wb_valid_i = 1'b0;
    chk_n++;
    if ({sb.full_o, sb.commit_valid_o} !== 2'b11)
      $display("FAIL fc_pre got=%b exp=11",
        {sb.full_o, sb.commit_valid_o});
    else pass_n++;
    sb.decoded_instr_i = mk(5'd9, MULT, 64'h999);
    sb.decoded_valid_i = 1'b1;
    sb.commit_ack_i    = 1'b1;
    #1;
    chk_n++;
    if (sb.decoded_ack_o !== 1'b0)
      $display("FAIL fc_same got=%b exp=0",
        sb.decoded_ack_o);
    else pass_n++;
    step();
    sb.commit_ack_i = 1'b0;
    #1;
    chk_n++;
    if ({sb.full_o, sb.decoded_ack_o} !== 2'b01)
      $display("FAIL fc_next got=%b exp=01",
        {sb.full_o, sb.decoded_ack_o});
    else pass_n++;
    step();
    sb.decoded_valid_i = 1'b0;
    chk_n++;
    if ({sb.full_o, sb.rd_clobber_o[9]}
        !== {1'b1, MULT})
      $display("FAIL fc_refill got=%0h exp=%0h",
        {sb.full_o, sb.rd_clobber_o[9]},
        {1'b1, MULT});
    else pass_n++;
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 5; i++)
      push_e(mk(5'(i + 1), ALU, 64'(i)));
    chk_n++;
    if (sb.rd_clobber_o[3] !== ALU)
      $display("FAIL fl_pre got=%0d exp=%0d",
        sb.rd_clobber_o[3], ALU);
    else pass_n++;
    sb.flush_i         = 1'b1;
    sb.decoded_instr_i = mk(5'd7, ALU, 64'h7);
    sb.decoded_valid_i = 1'b1;
    wb(3'd0, 64'h1);
    #1;
    chk_n++;
    if (sb.decoded_ack_o !== 1'b0)
      $display("FAIL fl_ack got=%b exp=0",
        sb.decoded_ack_o);
    else pass_n++;
    step();
    sb.flush_i         = 1'b0;
    sb.decoded_valid_i = 1'b0;
    sb.wb_valid_i      = 1'b0;
    chk_n++;
    if ({sb.full_o, sb.issue_valid_o,
         sb.commit_valid_o, sb.issue_trans_id_o}
        !== 6'b000000)
      $display("FAIL fl_state got=%b exp=000000",
        {sb.full_o, sb.issue_valid_o,
         sb.commit_valid_o, sb.issue_trans_id_o});
    else pass_n++;
    chk_n++;
    if (clob_clear() !== 1'b1)
      $display("FAIL fl_clob got=busy exp=NONE");
    else pass_n++;
    for (int i = 0; i < 7; i++)
      push_e(mk(5'd1, ALU, 64'(i)));
    chk_n++;
    if (sb.full_o !== 1'b0)
      $display("FAIL fl_cnt7 got=%b exp=0",
        sb.full_o);
    else pass_n++;
    push_e(mk(5'd1, ALU, 64'h8));
    chk_n++;
    if (sb.full_o !== 1'b1)
      $display("FAIL fl_cnt8 got=%b exp=1",
        sb.full_o);
    else pass_n++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++)
      push_e(mk(5'(i + 1), STORE, 64'(i)));
    wb(3'd0, 64'h77);
    step();
    sb.wb_valid_i = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.rs1_i = 5'd1;
    #1;
    chk_n++;
    if ({sb.full_o, sb.issue_valid_o,
         sb.commit_valid_o, sb.rs1_valid_o}
        !== 4'b0000)
      $display("FAIL rm_flags got=%b exp=0000",
        {sb.full_o, sb.issue_valid_o,
         sb.commit_valid_o, sb.rs1_valid_o});
    else pass_n++;
    chk_n++;
    if (clob_clear() !== 1'b1)
      $display("FAIL rm_clob got=busy exp=NONE");
    else pass_n++;
    push_e(mk(5'd7, CSR, 64'hABC));
    chk_n++;
    if ({sb.issue_valid_o, sb.issue_trans_id_o,
         sb.issue_instr_o.pc}
        !== {1'b1, 3'd0, 64'hABC})
      $display("FAIL rm_push got=%0h exp=%0h",
        {sb.issue_valid_o, sb.issue_trans_id_o,
         sb.issue_instr_o.pc},
        {1'b1, 3'd0, 64'hABC});
    else pass_n++;
    chk_n++;
    if (sb.rd_clobber_o[7] !== CSR)
      $display("FAIL rm_clob7 got=%0d exp=%0d",
        sb.rd_clobber_o[7], CSR);
    else pass_n++;
  endtask

  initial begin
    sb.flush_i         = 1'b0;
    sb.decoded_instr_i = '0;
    sb.decoded_valid_i = 1'b0;
    sb.issue_ack_i     = 1'b0;
    sb.wb_valid_i      = 1'b0;
    sb.wb_trans_id_i   = '0;
    sb.wb_result_i     = '0;
    sb.wb_ex_i         = '0;
    sb.commit_ack_i    = 1'b0;
    sb.rs1_i           = '0;
    sb.rs2_i           = '0;
    test_reset();
    test_fill();
    test_ooo_wb();
    test_forward();
    test_full_commit();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end
endmodule
